// File: rtl/am2950_pkg.sv
// am2950_pkg -- shared types and defaults for the am2950_port bidirectional
// register port.
//   flag_state_t : per-direction data-valid flag state (EMPTY / FULL)
//   DEF_WIDTH    : default bus/register width
//   DEF_INVERT   : default output polarity (1 = inverting bus drivers)
// Optional feature macro: AM2950_PORT_PARITY_EN (adds registered odd parity).
package am2950_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } flag_state_t;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_INVERT = 1;

`ifdef AM2950_PORT_PARITY_EN
   // Odd parity bit: set so that data plus parity holds an odd number of ones.
   function automatic logic odd_parity(input logic [31:0] v);
      return ~(^v);
   endfunction
`endif

endpackage

// File: rtl/am2950_chan.sv
// am2950_chan -- one transfer direction of the am2950 port.
// Holds the data register, its data-valid flag FSM, the sticky overrun flag,
// the optional parity bit and the tristate driver onto the destination bus.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   src       : resolved value of the source bus
//   ld_       : active-low load of the register from src
//   clr_      : active-low consumer acknowledge (clears flag and overrun)
//   oe_       : active-low drive enable for the destination bus
//   drv       : destination bus drive (high-Z when oe_ is high)
//   f, ov     : data-valid flag, sticky overrun flag
//   par       : registered odd parity of the stored value
//               (only with AM2950_PORT_PARITY_EN)
//
// state | meaning
// EMPTY | no unacknowledged data in the register (f=0)
// FULL  | register holds data not yet acknowledged (f=1)
module am2950_chan
   import am2950_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int INVERT = DEF_INVERT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] src,
   input  logic             ld_,
   input  logic             clr_,
   input  logic             oe_,
   output logic [WIDTH-1:0] drv,
   output logic             f,
`ifdef AM2950_PORT_PARITY_EN
   output logic             par,
`endif
   output logic             ov
);

   logic [WIDTH-1:0] r;
   flag_state_t      st, st_nx;
   logic             ov_nx;

   always_ff @(posedge clk) begin
      if (rst)
         r <= '0;
      else if (!ld_)
         r <= src;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= EMPTY;
         ov <= 1'b0;
      end else begin
         st <= st_nx;
         ov <= ov_nx;
      end
   end

   // A load always wins over a same-edge clear; overrun is only raised by a
   // load into a FULL register that is not being acknowledged on that edge.
   always_comb begin
      st_nx = st;
      ov_nx = ov;
      case (st)
         EMPTY: begin
            if (!ld_)
               st_nx = FULL;
         end
         FULL: begin
            if (!ld_) begin
               if (clr_)
                  ov_nx = 1'b1;
            end else if (!clr_) begin
               st_nx = EMPTY;
               ov_nx = 1'b0;
            end
         end
         default: begin
            st_nx = EMPTY;
            ov_nx = 1'b0;
         end
      endcase
   end

   assign f = (st == FULL);

   assign drv = oe_ ? {WIDTH{1'bz}} : ((INVERT != 0) ? ~r : r);

`ifdef AM2950_PORT_PARITY_EN
   // Parity follows the stored (non-inverted) value, so it reloads with r.
   always_ff @(posedge clk) begin
      if (rst)
         par <= 1'b1;
      else if (!ld_)
         par <= odd_parity({{(32-WIDTH){1'b0}}, src});
   end
`endif

endmodule

// File: rtl/am2950_port.sv
// am2950_port -- bidirectional registered bus port (Am2950-style).
// Register RAB captures bus a and drives bus b; register RBA captures bus b
// and drives bus a. Each direction has a data-valid flag and a sticky
// overrun flag.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   a, b            : bidirectional buses
//   lda_, ldb_      : active-low load RAB from a / RBA from b
//   oeb_, oea_      : active-low drive b from RAB / a from RBA
//   clrab_, clrba_  : active-low acknowledge of fab / fba
//   fab, fba        : data-valid flags
//   ovab, ovba      : sticky overrun flags
//   pab, pba        : registered odd parity of RAB / RBA
//                     (only with AM2950_PORT_PARITY_EN)
// Optional feature macro: AM2950_PORT_PARITY_EN.
module am2950_port
   import am2950_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int INVERT = DEF_INVERT
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] a,
   inout  wire  [WIDTH-1:0] b,
   input  logic             lda_,
   input  logic             ldb_,
   input  logic             oeb_,
   input  logic             oea_,
   input  logic             clrab_,
   input  logic             clrba_,
   output logic             fab,
   output logic             fba,
`ifdef AM2950_PORT_PARITY_EN
   output logic             pab,
   output logic             pba,
`endif
   output logic             ovab,
   output logic             ovba
);

   // Loopback (oeb_=0 with ldb_=0) needs no special handling: RBA simply
   // samples whatever value is resolved on b, including our own drive.
   am2950_chan #(.WIDTH(WIDTH), .INVERT(INVERT)) u_ab (
      .clk  (clk),
      .rst  (rst),
      .src  (a),
      .ld_  (lda_),
      .clr_ (clrab_),
      .oe_  (oeb_),
      .drv  (b),
      .f    (fab),
`ifdef AM2950_PORT_PARITY_EN
      .par  (pab),
`endif
      .ov   (ovab)
   );

   am2950_chan #(.WIDTH(WIDTH), .INVERT(INVERT)) u_ba (
      .clk  (clk),
      .rst  (rst),
      .src  (b),
      .ld_  (ldb_),
      .clr_ (clrba_),
      .oe_  (oea_),
      .drv  (a),
      .f    (fba),
`ifdef AM2950_PORT_PARITY_EN
      .par  (pba),
`endif
      .ov   (ovba)
   );

endmodule

// File: doc/am2950_port.md
AM2950_PORT -- requirements
Module: am2950_port

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bus and register width (legal range 1..32).
REQ-002 Parameter INVERT, default 1, SHALL select inverting bus outputs when 1 and true outputs when 0.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 a  inout  WIDTH  SHALL be bus A: source for register RAB and destination of register RBA.
REQ-006 b  inout  WIDTH  SHALL be bus B: source for register RBA and destination of register RAB.
REQ-007 lda_  input  1  SHALL be active low: load RAB from bus a.
REQ-008 ldb_  input  1  SHALL be active low: load RBA from bus b.
REQ-009 oeb_  input  1  SHALL be active low: drive bus b from RAB.
REQ-010 oea_  input  1  SHALL be active low: drive bus a from RBA.
REQ-011 clrab_ and clrba_  input  1 each  SHALL be active low: consumer acknowledges that clear flag fab and flag fba respectively.
REQ-012 fab and fba  output  1 each  SHALL be the data-valid flags of RAB and RBA.
REQ-013 ovab and ovba  output  1 each  SHALL be sticky overrun flags.

Function
REQ-014 On an edge with lda_=0, RAB SHALL capture the resolved value of a (not inverted); with lda_=1, RAB SHALL hold.
REQ-015 On an edge with ldb_=0, RBA SHALL capture the resolved value of b; with ldb_=1, RBA SHALL hold.
REQ-016 Bus b SHALL be driven combinationally with (INVERT ? ~RAB : RAB) while oeb_=0, else it SHALL be high-Z; latency from oeb_ SHALL be zero cycles.
REQ-017 Bus a SHALL be driven with (INVERT ? ~RBA : RBA) while oea_=0, else it SHALL be high-Z.
REQ-018 Each flag FSM (per direction) SHALL have two states, EMPTY (f=0) and FULL (f=1): a load moves it to FULL; a clear with no load moves it to EMPTY.
REQ-019 When load and clear occur on the same edge, load SHALL win: the flag ends FULL and the overrun flag is unaffected.
REQ-020 A load while the flag is already FULL with no clear on that edge SHALL set the overrun flag (ovab/ovba), and the new data SHALL still be captured.
REQ-021 The overrun flag SHALL remain set until a clear edge without a load, which SHALL reset both the flag and the overrun flag.
REQ-022 Loopback (oeb_=0 and ldb_=0 together) SHALL load RBA with the driven value of b; this is defined behaviour, not an error.
REQ-023 The external source and the device driving the same bus at once is a user contention error, and the model SHALL NOT resolve it.

Reset
REQ-024 On an edge with rst=1, RAB and RBA SHALL become 0; fab, fba, ovab and ovba SHALL become 0; rst SHALL override load and clear.
REQ-025 Bus drive SHALL remain governed solely by oea_ and oeb_ during reset, so a reset register drives all-zeros (or all-ones when INVERT=1).

Configuration
REQ-026 With macro AM2950_PORT_PARITY_EN defined, outputs pab and pba (1 bit each) SHALL present the registered odd parity of RAB and RBA (stored value, before inversion), updated on the same edge as the data and reset to 1.
REQ-027 Without AM2950_PORT_PARITY_EN, pab and pba SHALL not exist, and no parity logic SHALL be present.

Structure
REQ-028 Package am2950_pkg SHALL hold the flag-state enum (EMPTY, FULL) and constants DEF_WIDTH=8 and DEF_INVERT=1.
REQ-029 Sub-module am2950_chan SHALL implement one direction (register, flag FSM, overrun, optional parity, tristate driver) and SHALL be instantiated twice.

Verification
REQ-030 With rst=1 for one edge, then all controls high: a=b=Z, and fab=fba=ovab=ovba=0.
REQ-031 a=8'b00110011, lda_=0 for one edge, then oeb_=0 with INVERT=1: b=8'b11001100 and fab=1; with clrab_=0 for one edge, fab=0.
REQ-032 b=8'b01010101, ldb_=0 for one edge, then oea_=0: a=8'b10101010 and fba=1; with INVERT=0, a=8'b01010101.
REQ-033 Two lda_ loads without a clear (0x11 then 0x22): ovab=1 and RAB=0x22; simultaneous lda_=0 and clrab_=0: fab=1; a clear alone gives fab=ovab=0.
REQ-034 rst=1 asserted mid-operation with lda_=0 and a=0xFF: RAB=0, fab=0; with parity enabled, pab=1 after reset and pab=0 after loading 0x01.
